// File: rtl/dcache_refill_pkg.sv
// rtl/dcache_refill_pkg.sv - shared refill types, block geometry and address field positions
package dcache_pkg;

  localparam int BLOCK_W         = 64;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 2;
  localparam int OFFSET_BIT      = 2;
  localparam int SET_LSB         = 3;
  localparam int SET_W           = 7;
  localparam int TAG_LSB         = SET_LSB + SET_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH_A = 2'd1,
    ST_FETCH_B = 2'd2,
    ST_DONE    = 2'd3
  } refill_state_e;

  // Offset 0 lives in the upper half of the block, offset 1 in the lower half.
  function automatic logic [BLOCK_W-1:0] merge_word(input logic [BLOCK_W-1:0] blk,
                                                    input logic              off,
                                                    input logic [WORD_W-1:0] word);
    merge_word = blk;
    if (off) merge_word[WORD_W-1:0] = word;
    else     merge_word[BLOCK_W-1:WORD_W] = word;
  endfunction

endpackage

// File: rtl/dcache_refill_if.sv
// rtl/dcache_refill_if.sv - cache-side and memory-side signals of the refill controller
interface dcache_refill_if #(
  parameter int ADDR_W = 32
);
  import dcache_pkg::*;

  logic                miss_req;
  logic [ADDR_W-1:0]   miss_addr;
  logic                miss_ready;
  logic [BLOCK_W-1:0]  datain;
  logic                dready;
  logic                refill_err;
  logic                mem_req;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_ack;
  logic [WORD_W-1:0]   mem_rdata;

  modport master (
    output miss_req, miss_addr, mem_ack, mem_rdata,
    input  miss_ready, datain, dready, refill_err, mem_req, mem_addr
  );

  modport slave (
    input  miss_req, miss_addr, mem_ack, mem_rdata,
    output miss_ready, datain, dready, refill_err, mem_req, mem_addr
  );

endinterface

// File: rtl/dcache_refill_timeout.sv
// rtl/dcache_refill_timeout.sv - per-word wait counter flagging expiry at TIMEOUT_CYC
module refill_timeout #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic CLK,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [15:0] r_cnt;

  // count cycles spent waiting for an ack; clear has priority over enable
  always_ff @(posedge CLK) begin
    if (reset || i_clr) r_cnt <= '0;
    else if (i_en)      r_cnt <= r_cnt + 16'd1;
  end

  // flags the waiting cycle whose increment would bring the count to TIMEOUT_CYC,
  // so mem_req is held for exactly TIMEOUT_CYC cycles before the abort
  assign o_expire = i_en && (r_cnt == 16'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/dcache_refill.sv
// rtl/dcache_refill.sv - data-cache miss refill controller; define DCACHE_REFILL_CWF_EN for critical-word-first
module dcache_refill #(
  parameter int TIMEOUT_CYC = 255,
  parameter int ADDR_W      = 32
) (
  input logic           CLK,
  input logic           reset,
  dcache_refill_if.slave bus
);
  import dcache_pkg::*;

`ifdef DCACHE_REFILL_CWF_EN
  localparam logic CWF = 1'b1;
`else
  localparam logic CWF = 1'b0;
`endif

  refill_state_e             r_state;
  refill_state_e             w_next;
  logic [ADDR_W-1:OFFSET_BIT+1] r_blk;
  logic                      r_wsel;
  logic [BLOCK_W-1:0]        r_datain;
  logic                      r_err;
  logic                      w_err_set;
  logic                      w_accept;
  logic                      w_store;
  logic                      w_fetch;
  logic                      w_off;
  logic                      w_clr;
  logic                      w_en;
  logic                      w_expire;
  logic                      w_unused;

  assign w_fetch  = (r_state == ST_FETCH_A) || (r_state == ST_FETCH_B);
  // FETCH_A takes the critical word when CWF is on, otherwise offset 0
  assign w_off    = (r_state == ST_FETCH_B) ^ (CWF & r_wsel);
  assign w_en     = w_fetch && !bus.mem_ack;
  // counter restarts whenever a fetch state is (re)entered or we are not fetching
  assign w_clr    = !w_fetch || (w_next != r_state);
  assign w_unused = &{1'b0, bus.miss_addr[OFFSET_BIT-1:0]};

  refill_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .CLK      (CLK),
    .reset    (reset),
    .i_clr    (w_clr),
    .i_en     (w_en),
    .o_expire (w_expire)
  );

  // next-state and strobe decode
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_store   = 1'b0;
    w_err_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.miss_req) begin
          w_next   = ST_FETCH_A;
          w_accept = 1'b1;
        end
      end
      ST_FETCH_A: begin
        if (bus.mem_ack) begin
          w_next  = ST_FETCH_B;
          w_store = 1'b1;
        end else if (w_expire) begin
          w_next    = ST_IDLE;
          w_err_set = 1'b1;
        end
      end
      ST_FETCH_B: begin
        if (bus.mem_ack) begin
          w_next  = ST_DONE;
          w_store = 1'b1;
        end else if (w_expire) begin
          w_next    = ST_IDLE;
          w_err_set = 1'b1;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge CLK) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // latch block address and critical-word select when a miss is accepted
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_blk  <= '0;
      r_wsel <= 1'b0;
    end else if (w_accept) begin
      r_blk  <= bus.miss_addr[ADDR_W-1:OFFSET_BIT+1];
      r_wsel <= bus.miss_addr[OFFSET_BIT];
    end
  end

  // place each returned word into its slot of the block
  always_ff @(posedge CLK) begin
    if (reset)        r_datain <= '0;
    else if (w_store) r_datain <= merge_word(r_datain, w_off, bus.mem_rdata);
  end

  // one-cycle abort pulse, raised in the first IDLE cycle after a timeout
  always_ff @(posedge CLK) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= w_err_set;
  end

  assign bus.miss_ready = (r_state == ST_IDLE);
  assign bus.dready     = (r_state == ST_DONE);
  assign bus.refill_err = r_err;
  assign bus.mem_req    = w_fetch;
  assign bus.mem_addr   = {r_blk, w_off, {OFFSET_BIT{1'b0}}};
  assign bus.datain     = r_datain;

endmodule

// File: tb/tb_dcache_refill.sv
// tb/tb_dcache_refill.sv - scoreboard bench for dcache_refill; honours DCACHE_REFILL_CWF_EN
module tb_dcache_refill;
  import dcache_pkg::*;

  localparam int EV_WORD  = 0;
  localparam int EV_BLOCK = 1;
  localparam int EV_ERR   = 2;

  typedef struct {
    int          kind;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rsp_left = -1;
  exp_t exp_q[$];
  int   wait_q[$];
  logic [31:0] mem [logic [31:0]];

  dcache_refill_if #(.ADDR_W(32)) bus ();
  dcache_refill_if #(.ADDR_W(32)) bus_to ();

  dcache_refill #(.TIMEOUT_CYC(255), .ADDR_W(32)) u_dut (
    .CLK(clk), .reset(rst), .bus(bus.slave)
  );

  dcache_refill #(.TIMEOUT_CYC(4), .ADDR_W(32)) u_dut_to (
    .CLK(clk), .reset(rst), .bus(bus_to.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input logic [63:0] data, input int at);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic expect_ev(input int kind, input logic [63:0] data, input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_unexpected: got %h at cycle %0d, required no event", name, data, cyc);
    end else begin
      e = exp_q.pop_front();
      check({name, "_kind"}, 64'(kind), 64'(e.kind));
      check({name, "_data"}, data, e.data);
      check({name, "_cycle"}, 64'(cyc), 64'(e.cyc));
    end
  endtask

  // monitor: every accepted word, dready and refill_err pops one expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_req && bus.mem_ack)
        expect_ev(EV_WORD, {32'h0, bus.mem_addr}, "word");
      else if (bus.mem_req && exp_q.size() > 0 && exp_q[0].kind == EV_WORD)
        check("addr_hold", {32'h0, bus.mem_addr}, exp_q[0].data);
      if (bus.dready)     expect_ev(EV_BLOCK, bus.datain, "block");
      if (bus.refill_err) expect_ev(EV_ERR, 64'h0, "abort");
    end
  end

  // memory model: ack each word after the wait count queued for it
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'hBAD0_0000 ^ 32'(cyc);
      if (bus.mem_req && !rst) begin
        if (rsp_left < 0) rsp_left = (wait_q.size() > 0) ? wait_q.pop_front() : 1000;
        if (rsp_left == 0) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'h0;
          rsp_left      = -1;
        end else begin
          rsp_left--;
        end
      end else begin
        rsp_left = -1;
      end
    end
  end

  task automatic push_fill(input int w0, input int w1, input logic [31:0] a0,
                           input logic [31:0] a1, input logic [63:0] blk);
    push_ev(EV_WORD, {32'h0, a0}, cyc + w0);
    push_ev(EV_WORD, {32'h0, a1}, cyc + w0 + 1 + w1);
    push_ev(EV_BLOCK, blk, cyc + w0 + w1 + 2);
    wait_q.push_back(w0);
    wait_q.push_back(w1);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.miss_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.miss_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: miss_ready=0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d events outstanding, required 0", exp_q.size());
      exp_q.delete();
      wait_q.delete();
    end
  endtask

  task automatic do_miss(input logic [31:0] addr, input int w0, input int w1,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [63:0] blk);
    wait_ready();
    bus.miss_req  = 1'b1;
    bus.miss_addr = addr;
    @(posedge clk);
    #1;
    push_fill(w0, w1, a0, a1, blk);
    bus.miss_req  = 1'b0;
    bus.miss_addr = 32'hFFFF_FFF8;
    drain();
  endtask

  initial begin
    int  c0;
    bit  done;
    bus.miss_req     = 1'b0;
    bus.miss_addr    = 32'h0;
    bus_to.miss_req  = 1'b0;
    bus_to.miss_addr = 32'h0;
    bus_to.mem_ack   = 1'b0;
    bus_to.mem_rdata = 32'h0;
    mem[32'h1008] = 32'hAAAA_0000;  mem[32'h100C] = 32'hBBBB_0004;
    mem[32'h1100] = 32'h1111_2222;  mem[32'h1104] = 32'h3333_4444;
    mem[32'h2008] = 32'hC0DE_2008;  mem[32'h200C] = 32'hC0DE_200C;
    mem[32'h7000] = 32'h7000_AAAA;
    mem[32'h7008] = 32'h5555_6666;  mem[32'h700C] = 32'h7777_8888;
    mem[32'h3000] = 32'h3000_0001;  mem[32'h3004] = 32'h3000_0002;
    mem[32'h4008] = 32'h4000_0001;  mem[32'h400C] = 32'h4000_0002;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_miss_ready", 64'(bus.miss_ready), 64'd1);
    check("rst_mem_req",    64'(bus.mem_req),    64'd0);
    check("rst_mem_addr",   64'(bus.mem_addr),   64'd0);
    check("rst_datain",     bus.datain,          64'd0);
    check("rst_dready",     64'(bus.dready),     64'd0);
    check("rst_refill_err", 64'(bus.refill_err), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // timeout instance: stray ack while idle is ignored, then abort after 4 waiting cycles
    @(negedge clk);
    bus_to.mem_ack   = 1'b1;
    bus_to.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    bus_to.mem_ack = 1'b0;
    check("to_idle_ack_datain",  bus_to.datain,            64'd0);
    check("to_idle_ack_mem_req", 64'(bus_to.mem_req),      64'd0);
    check("to_idle_ack_ready",   64'(bus_to.miss_ready),   64'd1);
    bus_to.miss_req  = 1'b1;
    bus_to.miss_addr = 32'h8000;
    @(posedge clk);
    #1 bus_to.miss_req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("to_mem_req",    64'(bus_to.mem_req),    64'(k <= 4));
      check("to_mem_addr",   64'(bus_to.mem_addr),   (k <= 4) ? 64'h8000 : 64'(bus_to.mem_addr));
      check("to_refill_err", 64'(bus_to.refill_err), 64'(k == 5));
      check("to_dready",     64'(bus_to.dready),     64'd0);
      check("to_miss_ready", 64'(bus_to.miss_ready), 64'(k >= 5));
    end

    // zero-wait fill
    do_miss(32'h1008, 0, 0, 32'h1008, 32'h100C, 64'hAAAA_0000_BBBB_0004);
    // wait states: 2 on the first word, 5 on the second
    do_miss(32'h1100, 2, 5, 32'h1100, 32'h1104, 64'h1111_2222_3333_4444);
    // fetch order depends on critical-word-first; placement never does
`ifdef DCACHE_REFILL_CWF_EN
    do_miss(32'h200C, 0, 1, 32'h200C, 32'h2008, 64'hC0DE_2008_C0DE_200C);
`else
    do_miss(32'h200C, 0, 1, 32'h2008, 32'h200C, 64'hC0DE_2008_C0DE_200C);
`endif

    // reset while waiting in FETCH_B
    wait_ready();
    bus.miss_req  = 1'b1;
    bus.miss_addr = 32'h7000;
    @(posedge clk);
    #1;
    push_ev(EV_WORD, 64'h7000, cyc);
    wait_q.push_back(0);
    wait_q.push_back(100);
    bus.miss_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_fetch_b_req",  64'(bus.mem_req),  64'd1);
    check("mid_fetch_b_addr", 64'(bus.mem_addr), 64'h7004);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_mem_req",    64'(bus.mem_req),    64'd0);
    check("mid_rst_miss_ready", 64'(bus.miss_ready), 64'd1);
    check("mid_rst_dready",     64'(bus.dready),     64'd0);
    check("mid_rst_refill_err", 64'(bus.refill_err), 64'd0);
    repeat (3) @(negedge clk);
    wait_q.delete();
    do_miss(32'h7008, 1, 0, 32'h7008, 32'h700C, 64'h5555_6666_7777_8888);

    // miss_req held with changing address: only the accepted one is fetched
    wait_ready();
    bus.miss_req  = 1'b1;
    bus.miss_addr = 32'h3000;
    @(posedge clk);
    #1;
    c0 = cyc;
    push_fill(0, 0, 32'h3000, 32'h3004, 64'h3000_0001_3000_0002);
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (bus.miss_ready) done = 1'b1;
      else bus.miss_addr = k[0] ? 32'h5000 : 32'h600C;
    end
    check("b2b_ready_cycle", 64'(cyc), 64'(c0 + 3));
    bus.miss_addr = 32'h4008;
    @(posedge clk);
    #1;
    push_fill(0, 0, 32'h4008, 32'h400C, 64'h4000_0001_4000_0002);
    bus.miss_req = 1'b0;
    drain();

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
